// File: rtl/crop_ctrl.sv
// crop_ctrl: frame sequencer for a streaming crop filter.
// Holds a pending crop origin (clamped so the window stays inside the frame),
// promotes it to the active origin at each frame arm, kicks the filter with
// ap_start, tracks the (row, col) position of the next beat and reports frame
// completion once the filter signals done.
//
// Optional feature: define CROP_CTRL_SOF_RESYNC_EN to realign the position
// counters on a start-of-frame beat and flag a sync_err pulse on misalignment.
//
// Handshake semantics: a configuration is accepted on any cycle where
// cfg_valid && cfg_ready (cfg_ready is constant 1); a stream beat is counted on
// any cycle where beat_fire is high while in RUN, and ignored otherwise.
module crop_ctrl #(
    parameter int IN_ROWS  = 20,
    parameter int IN_COLS  = 20,
    parameter int OUT_ROWS = 10,
    parameter int OUT_COLS = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       continuous,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [$clog2(IN_COLS)-1:0] cfg_x0,
    input  logic [$clog2(IN_ROWS)-1:0] cfg_y0,
    input  logic                       beat_fire,
    input  logic                       beat_sof,
    output logic                       stream_en,
    output logic                       ap_start,
    input  logic                       filt_done,
    output logic [$clog2(IN_COLS)-1:0] crop_x0,
    output logic [$clog2(IN_ROWS)-1:0] crop_y0,
    output logic [$clog2(IN_COLS)-1:0] cnt_col,
    output logic [$clog2(IN_ROWS)-1:0] cnt_row,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       cfg_clamped,
    output logic                       sync_err,
    output logic [15:0]                frame_cnt,
    output logic [1:0]                 dbg_state
);

    localparam int XW = $clog2(IN_COLS);
    localparam int YW = $clog2(IN_ROWS);
    localparam logic [XW-1:0] MAX_X    = XW'(IN_COLS - OUT_COLS);
    localparam logic [YW-1:0] MAX_Y    = YW'(IN_ROWS - OUT_ROWS);
    localparam logic [XW-1:0] LAST_COL = XW'(IN_COLS - 1);
    localparam logic [YW-1:0] LAST_ROW = YW'(IN_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   pend_x_q, pend_x_d;
    logic [YW-1:0]   pend_y_q, pend_y_d;
    logic [XW-1:0]   crop_x_q, crop_x_d;
    logic [YW-1:0]   crop_y_q, crop_y_d;
    logic [XW-1:0]   col_q, col_d;
    logic [YW-1:0]   row_q, row_d;
    logic            clamped_q, clamped_d;
    logic            frame_done_q, frame_done_d;
    logic            sync_err_q, sync_err_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            sof_hit;
    logic            at_last;
    logic            arm_entry;

`ifdef CROP_CTRL_SOF_RESYNC_EN
    assign sof_hit = beat_sof;
`else
    // beat_sof has no effect in this build; keep it visibly consumed.
    logic unused_beat_sof;
    assign unused_beat_sof = beat_sof;
    assign sof_hit = 1'b0;
`endif

    assign at_last   = (col_q == LAST_COL) && (row_q == LAST_ROW);
    assign arm_entry = (state_d == ARM) && (state_q != ARM);

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start || continuous) state_d = ARM;
            ARM:     state_d = RUN;
            RUN:     if (beat_fire && !sof_hit && at_last) state_d = DRAIN;
            DRAIN:   if (filt_done) state_d = continuous ? ARM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: pending/active origin, position counters, status.
    always_comb begin
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        clamped_d    = clamped_q;
        crop_x_d     = crop_x_q;
        crop_y_d     = crop_y_q;
        col_d        = col_q;
        row_d        = row_q;
        sync_err_d   = 1'b0;
        frame_done_d = (state_q == DRAIN) && filt_done;
        frame_cnt_d  = frame_done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;

        if (cfg_valid) begin
            if (cfg_x0 > MAX_X) begin
                pend_x_d  = MAX_X;
                clamped_d = 1'b1;
            end else begin
                pend_x_d = cfg_x0;
            end
            if (cfg_y0 > MAX_Y) begin
                pend_y_d  = MAX_Y;
                clamped_d = 1'b1;
            end else begin
                pend_y_d = cfg_y0;
            end
        end

        // The active origin takes the pending value held before this edge, so a
        // cfg write on the same cycle is kept for the following frame.
        if (arm_entry) begin
            crop_x_d = pend_x_q;
            crop_y_d = pend_y_q;
            col_d    = '0;
            row_d    = '0;
        end else if ((state_q == RUN) && beat_fire) begin
            if (sof_hit) begin
                row_d      = '0;
                col_d      = XW'(1);
                sync_err_d = (col_q != '0) || (row_q != '0);
            end else if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + YW'(1);
            end else begin
                col_d = col_q + XW'(1);
            end
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            crop_x_q     <= '0;
            crop_y_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            clamped_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            crop_x_q     <= crop_x_d;
            crop_y_q     <= crop_y_d;
            col_q        <= col_d;
            row_q        <= row_d;
            clamped_q    <= clamped_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign cfg_ready   = 1'b1;
    assign stream_en   = (state_q == RUN);
    assign ap_start    = (state_q == ARM);
    assign busy        = (state_q != IDLE);
    assign crop_x0     = crop_x_q;
    assign crop_y0     = crop_y_q;
    assign cnt_col     = col_q;
    assign cnt_row     = row_q;
    assign frame_done  = frame_done_q;
    assign cfg_clamped = clamped_q;
    assign sync_err    = sync_err_q;
    assign frame_cnt   = frame_cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/crop_ctrl.md
CROP_CTRL -- requirements
Module: crop_ctrl

Interface
REQ-001 The block SHALL have parameter IN_ROWS, default 20, meaning input frame height in pixels.
REQ-002 The block SHALL have parameter IN_COLS, default 20, meaning input frame width in pixels.
REQ-003 The block SHALL have parameters OUT_ROWS and OUT_COLS, default 10 each, meaning crop window height and width; OUT_ROWS<=IN_ROWS and OUT_COLS<=IN_COLS.
REQ-004 The block SHALL have these ports:
 - clk  in  1  clock.
 - reset  in  1  reset, synchronous, active-high.
 - start  in  1  one-frame request pulse.
 - continuous  in  1  re-arm automatically after each frame.
 - cfg_valid  in  1  new crop origin offered.
 - cfg_ready  out  1  always 1 after reset.
 - cfg_x0  in  $clog2(IN_COLS)  requested column origin.
 - cfg_y0  in  $clog2(IN_ROWS)  requested row origin.
 - beat_fire  in  1  filter input handshake (tvalid&&tready).
 - beat_sof  in  1  start-of-frame user bit of the current beat.
 - stream_en  out  1  upstream may present beats.
 - ap_start  out  1  one-cycle pulse to the filter.
 - filt_done  in  1  filter ap_done.
 - crop_x0  out  $clog2(IN_COLS)  active column origin.
 - crop_y0  out  $clog2(IN_ROWS)  active row origin.
 - cnt_col  out  $clog2(IN_COLS)  column of the current beat.
 - cnt_row  out  $clog2(IN_ROWS)  row of the current beat.
 - busy  out  1  state != IDLE.
 - frame_done  out  1  one-cycle completion pulse.
 - cfg_clamped  out  1  sticky flag: a config value was clamped.
 - sync_err  out  1  one-cycle SOF-misalignment pulse.
 - frame_cnt  out  16  completed frames, wraps at 65535.

Function
REQ-005 A cfg_valid cycle SHALL write cfg_x0/cfg_y0 into a pending register, the last write winning; the active origin SHALL change only on entry to ARM.
REQ-006 Pending x0 above IN_COLS-OUT_COLS SHALL be stored as IN_COLS-OUT_COLS and SHALL set cfg_clamped; y0 SHALL be clamped the same way against IN_ROWS-OUT_ROWS.
REQ-007 The FSM SHALL have states IDLE, ARM, RUN and DRAIN.
 - IDLE->ARM on start or continuous.
 - ARM->RUN after exactly 1 cycle.
 - RUN->DRAIN on the beat at (IN_ROWS-1, IN_COLS-1).
 - DRAIN->ARM on filt_done when continuous=1, else DRAIN->IDLE on filt_done.
REQ-008 In ARM, the block SHALL assert ap_start for that cycle, load crop_x0/crop_y0 from pending, and zero both counters.
REQ-009 stream_en SHALL be 1 only in RUN; a beat_fire outside RUN SHALL be ignored.
REQ-010 cnt_col/cnt_row SHALL be registered and SHALL give the position of the next beat.
 - On beat_fire, col SHALL increment; at IN_COLS-1 it SHALL wrap to 0 and row SHALL increment.
 - At (IN_ROWS-1, IN_COLS-1) both SHALL wrap to 0.
REQ-011 frame_done SHALL pulse, and frame_cnt SHALL increment, in the cycle after filt_done is sampled in DRAIN; a filt_done in any other state SHALL be ignored.
REQ-012 A start pulse while busy SHALL be ignored; continuous SHALL be sampled only in IDLE and DRAIN.
REQ-013 A simultaneous cfg_valid and ARM entry SHALL load the old pending value into the active origin and retain the new value for the next frame.

Reset
REQ-014 On reset the block SHALL enter IDLE and SHALL clear counters, pending, active origin, cfg_clamped, frame_cnt and all pulses to 0; cfg_ready SHALL be 1.
REQ-015 A reset mid-RUN or mid-DRAIN SHALL abandon the frame without pulsing frame_done.

Configuration
REQ-016 With CROP_CTRL_SOF_RESYNC_EN defined, a RUN beat_fire with beat_sof=1 SHALL be treated as position (0,0), so the counters become (row 0, col 1). If the counters were not already (0,0), sync_err SHALL pulse.
REQ-017 Without CROP_CTRL_SOF_RESYNC_EN, beat_sof SHALL be ignored and sync_err SHALL be tied to 0.

Verification
REQ-018 The bench SHALL cover these scenarios (IN 20x20, OUT 10x10):
 - Single frame: cfg(3,4), start, 400 beats -> one ap_start pulse; crop_x0=3 and crop_y0=4; DRAIN after beat 400; filt_done -> frame_done, frame_cnt=1, IDLE.
 - Clamp: cfg(15,12) -> active origin (10,10), cfg_clamped=1.
 - Continuous with cfg(5,5) offered mid-frame -> the current frame keeps the old origin; the next ARM loads (5,5); ap_start again 1 cycle after filt_done.
 - Reset at beat 137 -> IDLE, counters 0, no frame_done; the next start runs a clean frame.
 - RESYNC_EN: beat_sof=1 on beat 50 -> sync_err pulse, counters (0,1); without the macro -> no pulse, counters (2,10).
 - start while busy, and filt_done in RUN -> no state change.
